// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
//   FRAME_BITS : serial frame length in bit periods (start + 8 data + stop)
//   tx_state_e : transmitter FSM states
//   calc_div   : bit period in system clocks, integer-truncated
package uart_pkg;

   localparam int unsigned FRAME_BITS = 10;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } tx_state_e;

   function automatic int unsigned calc_div(input int unsigned freq_mhz,
                                            input int unsigned bauds);
      return (freq_mhz * 1000000) / bauds;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular byte FIFO with first-word fall-through read data.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write strobe and byte; ignored while full (even if popping)
//   pop, dout     : read strobe and head byte; ignored while empty
//   level         : occupancy, 0 .. 2**DEPTH_LOG2
//   full, empty   : occupancy flags
// Storage is deliberately not reset; only pointers and occupancy are.
module uart_fifo #(
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [7:0]            din,
   input  logic                  pop,
   output logic [7:0]            dout,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty
);

   localparam logic [DEPTH_LOG2:0] Depth = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [7:0]            mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  push_ok;
   logic                  pop_ok;

   assign full    = (level_q == Depth);
   assign empty   = (level_q == '0);
   // Fullness is judged before any same-cycle pop.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr_q];
   assign level   = level_q;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            level_q <= level_q + 1'b1;
         end else if (!push_ok && pop_ok) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter, LSB first, idle-high line.
// Ports:
//   clk     : system clock, FREQ_MHZ MHz
//   resetq  : asynchronous active-high reset
//   wr      : push tx_data this cycle (dropped while busy)
//   tx_data : byte to queue
//   cts_n   : active-low clear-to-send (only when UART_TX_CTS_EN is defined)
//   tx      : registered serial output
//   busy    : FIFO full
//   idle    : FIFO empty and no frame in progress
//   level   : FIFO occupancy
// Build option: define UART_TX_CTS_EN to add cts_n flow control; a frame
// starts only while the synchronised cts_n is low, and always completes.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned FREQ_MHZ   = 12,
   parameter int unsigned BAUDS      = 115200,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  resetq,
   input  logic                  wr,
   input  logic [7:0]            tx_data,
`ifdef UART_TX_CTS_EN
   input  logic                  cts_n,
`endif
   output logic                  tx,
   output logic                  busy,
   output logic                  idle,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int unsigned     DIV       = calc_div(FREQ_MHZ, BAUDS);
   localparam int unsigned     CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
   localparam logic [3:0]      BIT_LAST  = 4'(FRAME_BITS - 1);

   tx_state_e        state_q;
   logic [9:0]       shift_q;
   logic [CNT_W-1:0] baud_q;
   logic [3:0]       bit_q;
   logic             tx_q;

   logic             fifo_pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [7:0]       fifo_dout;
   logic             cts_ok;
   logic             frame_end;

`ifdef UART_TX_CTS_EN
   logic cts_meta_q;
   logic cts_sync_q;

   // Reset to "not clear" so nothing starts before cts_n has been sampled.
   always_ff @(posedge clk or posedge resetq) begin
      if (resetq) begin
         cts_meta_q <= 1'b1;
         cts_sync_q <= 1'b1;
      end else begin
         cts_meta_q <= cts_n;
         cts_sync_q <= cts_meta_q;
      end
   end

   assign cts_ok = !cts_sync_q;
`else
   assign cts_ok = 1'b1;
`endif

   uart_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .rst   (resetq),
      .push  (wr),
      .din   (tx_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign frame_end = (state_q == StShift) && (bit_q == BIT_LAST) && (baud_q == BAUD_LAST);
   // A new frame may start from idle or directly at the end of a stop bit.
   assign fifo_pop  = !fifo_empty && cts_ok && ((state_q == StIdle) || frame_end);

   always_ff @(posedge clk or posedge resetq) begin
      if (resetq) begin
         state_q <= StIdle;
         shift_q <= '1;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         tx_q <= shift_q[0];
         if (fifo_pop) begin
            shift_q <= {1'b1, fifo_dout, 1'b0};
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StShift;
         end else if (state_q == StShift) begin
            if (baud_q == BAUD_LAST) begin
               baud_q  <= '0;
               // Shift in ones so the line rests high after the stop bit.
               shift_q <= {1'b1, shift_q[9:1]};
               if (bit_q == BIT_LAST) begin
                  bit_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  bit_q <= bit_q + 4'd1;
               end
            end else begin
               baud_q <= baud_q + 1'b1;
            end
         end
      end
   end

   assign tx   = tx_q;
   assign busy = fifo_full;
   assign idle = (state_q == StIdle) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A queue-based reference model tracks
// queued bytes and frame start times and derives the expected line level,
// occupancy and flags each cycle. Two DUTs: default rate and 48 MHz / 3 Mbaud.
module tb_uart_tx_fifo;

   localparam int DIV_MAIN = 104;
   localparam int DIV_FAST = 16;

   logic       clk = 1'b0;
   logic       resetq = 1'b0;
   logic       wr, wr_f;
   logic [7:0] tx_data, tx_data_f;
   logic       tx, busy, idle;
   logic [3:0] level;
   logic       tx_f, busy_f, idle_f;
   logic [3:0] level_f;
`ifdef UART_TX_CTS_EN
   logic       cts_n;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state.
   byte unsigned mq[$];
   bit           m_active;
   int           m_s;
   logic [7:0]   m_data;
   int           m_t;
`ifdef UART_TX_CTS_EN
   bit           m_c1, m_c2;
`endif

   // Per-cycle disagreement record, summarised by each test.
   int    mm_cnt;
   int    mm_cycle;
   string mm_sig;
   int    mm_act, mm_exp;

   always #5 clk = ~clk;

   uart_tx_fifo #(.FREQ_MHZ(12), .BAUDS(115200), .DEPTH_LOG2(3)) dut (
      .clk     (clk),
      .resetq  (resetq),
      .wr      (wr),
      .tx_data (tx_data),
`ifdef UART_TX_CTS_EN
      .cts_n   (cts_n),
`endif
      .tx      (tx),
      .busy    (busy),
      .idle    (idle),
      .level   (level)
   );

   uart_tx_fifo #(.FREQ_MHZ(48), .BAUDS(3000000), .DEPTH_LOG2(3)) dut_fast (
      .clk     (clk),
      .resetq  (resetq),
      .wr      (wr_f),
      .tx_data (tx_data_f),
`ifdef UART_TX_CTS_EN
      .cts_n   (cts_n),
`endif
      .tx      (tx_f),
      .busy    (busy_f),
      .idle    (idle_f),
      .level   (level_f)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit frame_bit(input logic [7:0] data, input int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return data[idx-1];
   endfunction

   task automatic model_clear();
      mq.delete();
      m_active = 1'b0;
      m_s      = 0;
      m_t      = 0;
`ifdef UART_TX_CTS_EN
      m_c1 = 1'b1;
      m_c2 = 1'b1;
`endif
   endtask

   task automatic note_mm(input string sig, input int act, input int exp_v);
      mm_cnt++;
      if (mm_cnt == 1) begin
         mm_cycle = m_t;
         mm_sig   = sig;
         mm_act   = act;
         mm_exp   = exp_v;
      end
   endtask

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic step(input bit fast, input bit w, input logic [7:0] d);
      int         div, k, sz;
      bit         free, cts_ok, exp_tx;
      logic [3:0] exp_lvl;
      logic       tx_a, busy_a, idle_a;
      logic [3:0] lvl_a;
      div = fast ? DIV_FAST : DIV_MAIN;
      if (fast) begin
         wr_f = w; tx_data_f = d;
      end else begin
         wr = w; tx_data = d;
      end
      @(posedge clk);
      exp_tx = 1'b1;
      if (m_active) begin
         k = m_t - m_s - 1;
         if (k >= 0 && k < 10 * div) exp_tx = frame_bit(m_data, k / div);
      end
      sz   = mq.size();
      free = !m_active || (m_t == m_s + 10 * div);
      if (free) m_active = 1'b0;
`ifdef UART_TX_CTS_EN
      cts_ok = !m_c2;
      m_c2   = m_c1;
      m_c1   = cts_n;
`else
      cts_ok = 1'b1;
`endif
      if (free && sz > 0 && cts_ok) begin
         m_data   = mq.pop_front();
         m_s      = m_t;
         m_active = 1'b1;
      end
      if (w && sz < 8) mq.push_back(d);
      m_t++;
      #1;
      exp_lvl = 4'(mq.size());
      tx_a   = fast ? tx_f : tx;
      busy_a = fast ? busy_f : busy;
      idle_a = fast ? idle_f : idle;
      lvl_a  = fast ? level_f : level;
      if (tx_a !== exp_tx) note_mm("tx", int'(tx_a), int'(exp_tx));
      if (lvl_a !== exp_lvl) note_mm("level", int'(lvl_a), int'(exp_lvl));
      if (busy_a !== (mq.size() == 8)) note_mm("busy", int'(busy_a), int'(mq.size() == 8));
      if (idle_a !== (!m_active && mq.size() == 0))
         note_mm("idle", int'(idle_a), int'(!m_active && mq.size() == 0));
      if (fast) wr_f = 1'b0; else wr = 1'b0;
   endtask

   task automatic drain(input bit fast, output bit timed_out);
      int n;
      n = 0;
      timed_out = 1'b0;
      while (m_active || mq.size() != 0) begin
         step(fast, 1'b0, 8'h00);
         n++;
         if (n > 20000) begin
            timed_out = 1'b1;
            break;
         end
      end
      repeat (4) step(fast, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      repeat (2) @(posedge clk);
      #1 resetq = 1'b0;
      model_clear();
   endtask

   task automatic test_single();
      logic       tx_mid [10];
      logic [9:0] exp_frame;
      logic       tx1, tx2, idle1040, idle1042;
      exp_frame = {1'b1, 8'h55, 1'b0};
      mm_cnt = 0;
      step(1'b0, 1'b1, 8'h55);
      for (int i = 1; i < 1050; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (i == 1) tx1 = tx;
         if (i == 2) tx2 = tx;
         if (i == 1040) idle1040 = idle;
         if (i == 1042) idle1042 = idle;
         if (i >= 54 && (i - 54) % 104 == 0 && (i - 54) / 104 < 10) tx_mid[(i - 54) / 104] = tx;
      end
      checks++; if (tx1 !== 1'b1) begin errors++; $display("FAIL single_tx_edge1: got %b want 1", tx1); end
      checks++; if (tx2 !== 1'b0) begin errors++; $display("FAIL single_tx_edge2: got %b want 0", tx2); end
      for (int b = 0; b < 10; b++) begin
         checks++;
         if (tx_mid[b] !== exp_frame[b]) begin
            errors++; $display("FAIL single_bit%0d: got %b want %b", b, tx_mid[b], exp_frame[b]);
         end
      end
      checks++; if (idle1040 !== 1'b0) begin errors++; $display("FAIL single_idle1040: got %b want 0", idle1040); end
      checks++; if (idle1042 !== 1'b1) begin errors++; $display("FAIL single_idle1042: got %b want 1", idle1042); end
      checks++;
      if (mm_cnt !== 0) begin
         errors++;
         $display("FAIL single_wave: %0d mismatches, first cycle %0d %s got %0d want %0d",
                  mm_cnt, mm_cycle, mm_sig, mm_act, mm_exp);
      end
   endtask

   task automatic test_fill_drop();
      logic       busy9, idle9360, idle9361;
      logic [3:0] lvl10;
      bit         to;
      mm_cnt = 0;
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(i));
      busy9 = busy;
      step(1'b0, 1'b1, 8'hFF);
      lvl10 = level;
      for (int i = 10; i < 9370; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (i == 9360) idle9360 = idle;
         if (i == 9361) idle9361 = idle;
      end
      drain(1'b0, to);
      checks++; if (busy9 !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b want 1", busy9); end
      checks++; if (lvl10 !== 4'd8) begin errors++; $display("FAIL fill_drop_level: got %0d want 8", lvl10); end
      checks++; if (idle9360 !== 1'b0) begin errors++; $display("FAIL fill_idle9360: got %b want 0", idle9360); end
      checks++; if (idle9361 !== 1'b1) begin errors++; $display("FAIL fill_idle9361: got %b want 1", idle9361); end
      checks++; if (to) begin errors++; $display("FAIL fill_drain: got timeout want drained"); end
      checks++;
      if (mm_cnt !== 0) begin
         errors++;
         $display("FAIL fill_wave: %0d mismatches, first cycle %0d %s got %0d want %0d",
                  mm_cnt, mm_cycle, mm_sig, mm_act, mm_exp);
      end
   endtask

   task automatic test_full_pop();
      logic [3:0] lvl_before, lvl_after;
      logic       busy_after;
      bit         to;
      mm_cnt = 0;
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 254)));
      for (int i = 9; i < 1041; i++) step(1'b0, 1'b0, 8'h00);
      lvl_before = level;
      step(1'b0, 1'b1, 8'hEE);
      lvl_after  = level;
      busy_after = busy;
      drain(1'b0, to);
      checks++; if (lvl_before !== 4'd8) begin errors++; $display("FAIL fullpop_before: got %0d want 8", lvl_before); end
      checks++; if (lvl_after !== 4'd7) begin errors++; $display("FAIL fullpop_level: got %0d want 7", lvl_after); end
      checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL fullpop_busy: got %b want 0", busy_after); end
      checks++; if (to) begin errors++; $display("FAIL fullpop_drain: got timeout want drained"); end
      checks++;
      if (mm_cnt !== 0) begin
         errors++;
         $display("FAIL fullpop_wave: %0d mismatches, first cycle %0d %s got %0d want %0d",
                  mm_cnt, mm_cycle, mm_sig, mm_act, mm_exp);
      end
   endtask

   task automatic test_random_stream();
      bit to;
      mm_cnt = 0;
      for (int i = 0; i < 3000; i++)
         step(1'b0, ($urandom_range(0, 99) < 5), 8'($urandom_range(0, 255)));
      drain(1'b0, to);
      checks++; if (to) begin errors++; $display("FAIL random_drain: got timeout want drained"); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL random_idle: got %b want 1", idle); end
      checks++;
      if (mm_cnt !== 0) begin
         errors++;
         $display("FAIL random_wave: %0d mismatches, first cycle %0d %s got %0d want %0d",
                  mm_cnt, mm_cycle, mm_sig, mm_act, mm_exp);
      end
   endtask

   task automatic test_reset_mid();
      logic       tx_pre, tx_rst, busy_rst, idle_rst;
      logic [3:0] lvl_rst;
      bit         to;
      mm_cnt = 0;
      step(1'b0, 1'b1, 8'hA3);
      for (int i = 1; i < 4; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      for (int i = 4; i <= 468; i++) step(1'b0, 1'b0, 8'h00);
      tx_pre = tx;
      #2 resetq = 1'b1;
      #1;
      tx_rst = tx; lvl_rst = level; busy_rst = busy; idle_rst = idle;
      #1 resetq = 1'b0;
      model_clear();
      for (int i = 0; i < 2000; i++) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      drain(1'b0, to);
      checks++; if (tx_pre !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got %b want 0", tx_pre); end
      checks++; if (tx_rst !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx_rst); end
      checks++; if (lvl_rst !== 4'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", lvl_rst); end
      checks++; if (busy_rst !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_rst); end
      checks++; if (idle_rst !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b want 1", idle_rst); end
      checks++; if (to) begin errors++; $display("FAIL rstmid_drain: got timeout want drained"); end
      checks++;
      if (mm_cnt !== 0) begin
         errors++;
         $display("FAIL rstmid_wave: %0d mismatches, first cycle %0d %s got %0d want %0d",
                  mm_cnt, mm_cycle, mm_sig, mm_act, mm_exp);
      end
   endtask

`ifdef UART_TX_CTS_EN
   task automatic test_cts();
      logic       tx_hold, tx3, tx4;
      logic [3:0] lvl_hold;
      bit         to;
      mm_cnt = 0;
      cts_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h41);
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 8'h00);
      tx_hold = tx; lvl_hold = level;
      cts_n = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         step(1'b0, 1'b0, 8'h00);
         if (j == 3) tx3 = tx;
         if (j == 4) tx4 = tx;
      end
      for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 8'h00);
      cts_n = 1'b1;
      drain(1'b0, to);
      cts_n = 1'b0;
      repeat (4) step(1'b0, 1'b0, 8'h00);
      checks++; if (tx_hold !== 1'b1) begin errors++; $display("FAIL cts_hold_tx: got %b want 1", tx_hold); end
      checks++; if (lvl_hold !== 4'd1) begin errors++; $display("FAIL cts_hold_level: got %0d want 1", lvl_hold); end
      checks++; if (tx3 !== 1'b1) begin errors++; $display("FAIL cts_start3: got %b want 1", tx3); end
      checks++; if (tx4 !== 1'b0) begin errors++; $display("FAIL cts_start4: got %b want 0", tx4); end
      checks++; if (to) begin errors++; $display("FAIL cts_drain: got timeout want drained"); end
      checks++;
      if (mm_cnt !== 0) begin
         errors++;
         $display("FAIL cts_wave: %0d mismatches, first cycle %0d %s got %0d want %0d",
                  mm_cnt, mm_cycle, mm_sig, mm_act, mm_exp);
      end
   endtask
`endif

   task automatic test_fast();
      logic [7:0] d0;
      logic       tx2, tx17, tx18;
      bit         to;
      model_clear();
`ifdef UART_TX_CTS_EN
      m_c1 = 1'b0; m_c2 = 1'b0;
`endif
      mm_cnt = 0;
      d0 = 8'($urandom_range(0, 255));
      step(1'b1, 1'b1, d0);
      for (int i = 1; i < 200; i++) begin
         step(1'b1, 1'b0, 8'h00);
         if (i == 2) tx2 = tx_f;
         if (i == 17) tx17 = tx_f;
         if (i == 18) tx18 = tx_f;
      end
      for (int n = 1; n < 20; n++) begin
         step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
         repeat ($urandom_range(100, 200)) step(1'b1, 1'b0, 8'h00);
      end
      drain(1'b1, to);
      checks++; if (tx2 !== 1'b0) begin errors++; $display("FAIL fast_start: got %b want 0", tx2); end
      checks++; if (tx17 !== 1'b0) begin errors++; $display("FAIL fast_start_end: got %b want 0", tx17); end
      checks++; if (tx18 !== d0[0]) begin errors++; $display("FAIL fast_d0: got %b want %b", tx18, d0[0]); end
      checks++; if (level_f !== 4'd0) begin errors++; $display("FAIL fast_level: got %0d want 0", level_f); end
      checks++; if (to) begin errors++; $display("FAIL fast_drain: got timeout want drained"); end
      checks++;
      if (mm_cnt !== 0) begin
         errors++;
         $display("FAIL fast_wave: %0d mismatches, first cycle %0d %s got %0d want %0d",
                  mm_cnt, mm_cycle, mm_sig, mm_act, mm_exp);
      end
      model_clear();
`ifdef UART_TX_CTS_EN
      m_c1 = 1'b0; m_c2 = 1'b0;
`endif
   endtask

   initial begin
      wr = 1'b0; tx_data = 8'h00; wr_f = 1'b0; tx_data_f = 8'h00;
`ifdef UART_TX_CTS_EN
      cts_n = 1'b0;
`endif
      #1 resetq = 1'b1;
      #2;
      test_reset();
      test_single();
      test_fill_drop();
      test_full_pop();
      test_random_stream();
      test_reset_mid();
`ifdef UART_TX_CTS_EN
      test_cts();
`endif
      test_fast();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
